// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbiter for the shared 4:1 2-bit select mux.
// Registers the grant, the select and the muxed word with a valid flag.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [1:0] d0,
  input  logic [1:0] d1,
  input  logic [1:0] d2,
  input  logic [1:0] d3,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic [1:0] o,
  output logic       o_valid,
  output logic       busy
);

  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      sel_q, sel_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [1:0]      o_q, o_d;
  logic            ov_q, ov_d;

  logic [3:0]      own_mask;
  logic [3:0]      others;
  logic [3:0]      cand;
  logic            keep;
  logic            win_ok;
  logic [1:0]      win;
  logic [1:0]      idx;
  logic [1:0]      dmux;

  always_comb begin
    own_mask = 4'b0001 << sel_q;
    others   = req & ~own_mask;
    keep     = 1'b0;
    cand     = req;
    if (state_q == GRANT && req[sel_q]) begin
      if (hold_q >= HOLD_MAX && |others) begin
        cand = others;
      end else begin
        keep = 1'b1;
        cand = '0;
      end
    end
  end

  // Walk from the farthest offset back so the nearest hit wins.
  always_comb begin
    win_ok = 1'b0;
    win    = ptr_q;
    idx    = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (cand[idx]) begin
        win_ok = 1'b1;
        win    = idx;
      end
    end
  end

  always_comb begin
    dmux = d0;
    case (sel_q)
      2'd0: dmux = d0;
      2'd1: dmux = d1;
      2'd2: dmux = d2;
      2'd3: dmux = d3;
      default: dmux = d0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    o_d     = o_q;
    ov_d    = 1'b0;
    if (state_q == GRANT) begin
      o_d  = dmux;
      ov_d = 1'b1;
    end
    if (keep) begin
      if (hold_q < HOLD_MAX) begin
        hold_d = hold_q + HOLD_ONE;
      end
    end else if (win_ok) begin
      state_d = GRANT;
      sel_d   = win;
      gnt_d   = 4'b0001 << win;
      ptr_d   = win + 2'd1;
      hold_d  = HOLD_ONE;
    end else begin
      state_d = IDLE;
      gnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      hold_q  <= '0;
      o_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
      o_q     <= o_d;
      ov_q    <= ov_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign o       = o_q;
  assign o_valid = ov_q;
  assign busy    = |gnt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: reference model predicts
// each edge, queue holds predictions until the outputs are sampled.
module tb_mux4_rr_arbiter;

  localparam int MH = 2;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] d0, d1, d2, d3;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [1:0] o;
  logic       o_valid;
  logic       busy;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [1:0] o;
    logic       ov;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];

  bit         m_busy;
  logic [1:0] m_sel;
  logic [1:0] m_ptr;
  int         m_hold;
  logic [1:0] m_o;
  bit         m_ov;

  mux4_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .d0      (d0),
    .d1      (d1),
    .d2      (d2),
    .d3      (d3),
    .gnt     (gnt),
    .sel     (sel),
    .o       (o),
    .o_valid (o_valid),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] dsel(input logic [1:0] s);
    case (s)
      2'd0: return d0;
      2'd1: return d1;
      2'd2: return d2;
      default: return d3;
    endcase
  endfunction

  task automatic model_step();
    logic [3:0] cand;
    logic [3:0] omask;
    bit keep;
    bit found;
    int w;
    exp_t e;
    if (!rst_n) begin
      m_busy = 0; m_sel = 0; m_ptr = 0; m_hold = 0; m_o = 0; m_ov = 0;
    end else begin
      m_ov = m_busy;
      if (m_busy) m_o = dsel(m_sel);
      omask = 4'b0001 << m_sel;
      keep = 0;
      cand = req;
      if (m_busy && req[m_sel]) begin
        if (m_hold >= MH && (req & ~omask) != 4'b0) cand = req & ~omask;
        else keep = 1;
      end
      if (keep) begin
        if (m_hold < MH) m_hold++;
      end else begin
        found = 0;
        w = 0;
        for (int i = 0; i < 4; i++) begin
          if (!found && cand[(int'(m_ptr) + i) % 4]) begin
            found = 1;
            w = (int'(m_ptr) + i) % 4;
          end
        end
        if (found) begin
          m_busy = 1;
          m_sel  = 2'(w);
          m_ptr  = 2'((w + 1) % 4);
          m_hold = 1;
        end else begin
          m_busy = 0;
        end
      end
    end
    e.gnt  = m_busy ? (4'b0001 << m_sel) : 4'b0000;
    e.sel  = m_sel;
    e.o    = m_o;
    e.ov   = m_ov;
    e.busy = m_busy;
    sb_q.push_back(e);
  endtask

  task automatic cyc(input logic [3:0] r, input logic rn);
    exp_t e;
    req   = r;
    rst_n = rn;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("gnt", 32'(gnt), 32'(e.gnt));
      check("sel", 32'(sel), 32'(e.sel));
      check("o", 32'(o), 32'(e.o));
      check("o_valid", 32'(o_valid), 32'(e.ov));
      check("busy", 32'(busy), 32'(e.busy));
      check("onehot", 32'($onehot0(gnt)), 32'd1);
    end
  endtask

  task automatic do_reset();
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
  endtask

  initial begin
    int own [9];
    n_cmp = 0;
    n_err = 0;
    req = '0; rst_n = 1'b0;
    d0 = 2'b10; d1 = 2'b01; d2 = 2'b11; d3 = 2'b00;
    m_busy = 0; m_sel = 0; m_ptr = 0; m_hold = 0; m_o = 0; m_ov = 0;
    @(negedge clk);

    // single requester grant, data and release
    do_reset();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_ov", 32'(o_valid), 32'h0);
    cyc(4'b0001, 1'b1);
    check("g0_gnt", 32'(gnt), 32'h1);
    check("g0_sel", 32'(sel), 32'h0);
    check("g0_ov", 32'(o_valid), 32'h0);
    cyc(4'b0001, 1'b1);
    check("g0_o", 32'(o), 32'h2);
    check("g0_ov1", 32'(o_valid), 32'h1);
    cyc(4'b0000, 1'b1);
    check("rel_gnt", 32'(gnt), 32'h0);
    check("rel_ov", 32'(o_valid), 32'h1);
    cyc(4'b0000, 1'b1);
    check("rel_ov0", 32'(o_valid), 32'h0);

    // full contention rotation with MAX_HOLD=2
    d0 = 2'd0; d1 = 2'd1; d2 = 2'd2; d3 = 2'd3;
    own = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cyc(4'b1111, 1'b1);
      check("rot_gnt", 32'(gnt), 32'(4'b0001 << own[i]));
      if (i > 0) check("rot_o", 32'(o), 32'(own[i-1]));
    end

    // lone owner is never preempted
    do_reset();
    for (int i = 0; i < 21; i++) begin
      cyc(4'b0100, 1'b1);
      check("lone_gnt", 32'(gnt), 32'h4);
    end

    // owner drop hands off with no idle cycle; ptr wraps to 0
    do_reset();
    cyc(4'b0010, 1'b1);
    check("h_gnt1", 32'(gnt), 32'h2);
    cyc(4'b1000, 1'b1);
    check("h_gnt3", 32'(gnt), 32'h8);
    check("h_busy", 32'(busy), 32'h1);
    cyc(4'b0000, 1'b1);
    cyc(4'b1111, 1'b1);
    check("h_ptr0", 32'(gnt), 32'h1);

    // reset mid-grant
    do_reset();
    repeat (3) cyc(4'b1111, 1'b1);
    cyc(4'b1111, 1'b0);
    check("mr_gnt", 32'(gnt), 32'h0);
    check("mr_sel", 32'(sel), 32'h0);
    check("mr_o", 32'(o), 32'h0);
    check("mr_ov", 32'(o_valid), 32'h0);
    cyc(4'b1111, 1'b1);
    check("mr_first", 32'(gnt), 32'h1);

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      d0 = 2'($urandom);
      d1 = 2'($urandom);
      d2 = 2'($urandom);
      d3 = 2'($urandom);
      cyc(4'($urandom), ($urandom_range(0, 499) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
